clock_divider_bank: RTL and testbench

//  Bank of NUM_CH independent, runtime-programmable clock dividers running off clk_10MHz.

---
 rtl/clock_divider_bank.sv | 90 +++++++++
 tb/tb_clock_divider_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// Bank of independent, runtime-programmable 50% clock dividers with glitch-free
// half-period reload through a shadow register and a global phase re-align.
module clock_divider_bank #(
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 16,
    parameter int RESET_HALF = 10000
) (
    input  logic              clk_10MHz,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [DIV_W-1:0]  wr_data,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] tick_rise
);

    localparam logic [DIV_W-1:0] RESET_VAL = DIV_W'(RESET_HALF);

    logic wr_bad;

    assign wr_bad = wr_en && ({1'b0, wr_ch} >= 5'(NUM_CH));

    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_bad;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] active_half;
        logic [DIV_W-1:0] shadow;
        logic [DIV_W-1:0] eff_half;
        logic [DIV_W-1:0] next_half;
        logic             hit;
        logic             wrap;
        logic             restart;
        logic             clk_q;
        logic             tick_q;
        logic             rise_q;
        logic             pend_q;

        assign hit       = wr_en && (wr_ch == 4'(i));
        assign eff_half  = (active_half == '0) ? DIV_W'(1) : active_half;
        assign wrap      = (cnt == eff_half - DIV_W'(1));
        assign restart   = sync || !ch_en[i];
        // A write landing on a reload point bypasses the shadow entirely.
        assign next_half = hit ? wr_data : (pend_q ? shadow : active_half);

        always_ff @(posedge clk_10MHz) begin
            if (rst) begin
                cnt         <= '0;
                active_half <= RESET_VAL;
                shadow      <= RESET_VAL;
                clk_q       <= 1'b0;
                tick_q      <= 1'b0;
                rise_q      <= 1'b0;
                pend_q      <= 1'b0;
            end else if (restart || wrap) begin
                cnt         <= '0;
                active_half <= next_half;
                pend_q      <= 1'b0;
                clk_q       <= restart ? 1'b0 : ~clk_q;
                tick_q      <= !restart;
                rise_q      <= !restart && !clk_q;
            end else begin
                cnt    <= cnt + DIV_W'(1);
                tick_q <= 1'b0;
                rise_q <= 1'b0;
                if (hit) begin
                    shadow <= wr_data;
                    pend_q <= 1'b1;
                end
            end
        end

        assign clk_out[i]   = clk_q;
        assign tick[i]      = tick_q;
        assign tick_rise[i] = rise_q;
        assign pending[i]   = pend_q;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: a timestamp-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_clock_divider_bank;

    localparam int NUM_CH     = 4;
    localparam int DIV_W      = 16;
    localparam int RESET_HALF = 10000;

    logic              clk_10MHz = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_ch = '0;
    logic [DIV_W-1:0]  wr_data = '0;
    logic              wr_err;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tick_rise;

    int checks = 0;
    int errors = 0;
    int ed = 0;
    bit cmp_on = 1'b0;

    clock_divider_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_HALF(RESET_HALF)
    ) dut (
        .clk_10MHz(clk_10MHz), .rst(rst), .ch_en(ch_en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .wr_err(wr_err),
        .pending(pending), .clk_out(clk_out), .tick(tick), .tick_rise(tick_rise)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    // Reference model: each channel remembers the absolute edge number of its next toggle.
    longint cyc = 0;
    longint due_m [NUM_CH];
    int     half_m[NUM_CH];
    int     shd_m [NUM_CH];
    bit     pend_m[NUM_CH];
    bit     lvl_m [NUM_CH];
    bit     tk_m  [NUM_CH];
    bit     tr_m  [NUM_CH];
    bit     err_m = 1'b0;

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    always @(posedge clk_10MHz) begin
        cyc++;
        if (rst) begin
            err_m = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                half_m[c] = RESET_HALF;
                shd_m[c]  = RESET_HALF;
                pend_m[c] = 1'b0;
                lvl_m[c]  = 1'b0;
                tk_m[c]   = 1'b0;
                tr_m[c]   = 1'b0;
                due_m[c]  = cyc + RESET_HALF;
            end
        end else begin
            err_m = wr_en && (int'(wr_ch) >= NUM_CH);
            for (int c = 0; c < NUM_CH; c++) begin
                bit wr;
                wr = wr_en && (int'(wr_ch) == c);
                if (sync || !ch_en[c] || cyc == due_m[c]) begin
                    if (sync || !ch_en[c]) begin
                        lvl_m[c] = 1'b0;
                        tk_m[c]  = 1'b0;
                        tr_m[c]  = 1'b0;
                    end else begin
                        lvl_m[c] = !lvl_m[c];
                        tk_m[c]  = 1'b1;
                        tr_m[c]  = lvl_m[c];
                    end
                    if (wr) half_m[c] = int'(wr_data);
                    else if (pend_m[c]) half_m[c] = shd_m[c];
                    pend_m[c] = 1'b0;
                    due_m[c]  = cyc + eff(half_m[c]);
                end else begin
                    tk_m[c] = 1'b0;
                    tr_m[c] = 1'b0;
                    if (wr) begin
                        shd_m[c]  = int'(wr_data);
                        pend_m[c] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, ed, got, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_10MHz) begin
        if (cmp_on) begin
            logic [NUM_CH-1:0] mc, mt, mr, mp;
            for (int c = 0; c < NUM_CH; c++) begin
                mc[c] = lvl_m[c];
                mt[c] = tk_m[c];
                mr[c] = tr_m[c];
                mp[c] = pend_m[c];
            end
            checkOutput("model clk_out",   32'(clk_out),   32'(mc));
            checkOutput("model tick",      32'(tick),      32'(mt));
            checkOutput("model tick_rise", 32'(tick_rise), 32'(mr));
            checkOutput("model pending",   32'(pending),   32'(mp));
            checkOutput("model wr_err",    32'(wr_err),    32'(err_m));
        end
    end

    task automatic step();
        @(posedge clk_10MHz);
        ed++;
        @(negedge clk_10MHz);
    endtask

    task automatic runTo(input int target);
        while (ed < target) step();
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic sy, input logic we,
                                 input logic [3:0] ch, input logic [DIV_W-1:0] data);
        ch_en   = en;
        sync    = sy;
        wr_en   = we;
        wr_ch   = ch;
        wr_data = data;
    endtask

    task automatic doReset(input logic [NUM_CH-1:0] en);
        applyStimulus(en, 1'b0, 1'b0, 4'd0, '0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ed = 0;
    endtask

    initial begin
        @(negedge clk_10MHz);
        doReset(4'hF);
        cmp_on = 1'b1;
        checkOutput("reset clk_out", 32'(clk_out), 32'h0);
        checkOutput("reset pending", 32'(pending), 32'h0);

        // Defaults, plus mid-period writes to ch1 (half 3) and ch2 (half 0).
        runTo(5000);
        applyStimulus(4'hF, 1'b0, 1'b1, 4'd1, 16'd3);
        step();
        checkOutput("pending ch1 set", 32'(pending), 32'h2);
        applyStimulus(4'hF, 1'b0, 1'b1, 4'd2, 16'd0);
        step();
        applyStimulus(4'hF, 1'b0, 1'b0, 4'd0, '0);
        checkOutput("pending ch1 ch2", 32'(pending), 32'h6);
        runTo(9999);
        checkOutput("ch0 low at 9999", 32'(clk_out[0]), 32'h0);
        checkOutput("pending held 9999", 32'(pending), 32'h6);
        runTo(10000);
        checkOutput("all rise at 10000", 32'(clk_out), 32'hF);
        checkOutput("tick_rise at 10000", 32'(tick_rise), 32'hF);
        checkOutput("pending applied", 32'(pending), 32'h0);
        step();
        checkOutput("ch2 toggles 10001", 32'(clk_out[2]), 32'h0);
        checkOutput("ch2 tick 10001", 32'(tick[2]), 32'h1);
        checkOutput("ch1 still high 10001", 32'(clk_out[1]), 32'h1);
        runTo(10003);
        checkOutput("ch1 low 10003", 32'(clk_out[1]), 32'h0);
        checkOutput("ch2 tick 10003", 32'(tick[2]), 32'h1);
        runTo(10006);
        checkOutput("ch1 high 10006", 32'(clk_out[1]), 32'h1);
        checkOutput("ch1 rise 10006", 32'(tick_rise[1]), 32'h1);
        runTo(19999);
        checkOutput("ch0 high 19999", 32'(clk_out[0]), 32'h1);
        runTo(20000);
        checkOutput("ch0 fall 20000", 32'(clk_out[0]), 32'h0);
        checkOutput("ch0 tick 20000", 32'(tick[0]), 32'h1);
        checkOutput("ch0 no rise 20000", 32'(tick_rise[0]), 32'h0);

        // Sync while ch0 is high at cnt 4999.
        doReset(4'hF);
        runTo(14999);
        checkOutput("ch0 high 14999", 32'(clk_out[0]), 32'h1);
        applyStimulus(4'hF, 1'b1, 1'b0, 4'd0, '0);
        step();
        applyStimulus(4'hF, 1'b0, 1'b0, 4'd0, '0);
        checkOutput("sync clears clk_out", 32'(clk_out), 32'h0);
        checkOutput("sync clears tick", 32'(tick), 32'h0);

        // Out-of-range write.
        runTo(16000);
        applyStimulus(4'hF, 1'b0, 1'b1, 4'd7, 16'd5);
        step();
        applyStimulus(4'hF, 1'b0, 1'b0, 4'd0, '0);
        checkOutput("wr_err pulse", 32'(wr_err), 32'h1);
        checkOutput("bad write no pending", 32'(pending), 32'h0);
        step();
        checkOutput("wr_err one cycle", 32'(wr_err), 32'h0);
        runTo(24999);
        checkOutput("ch0 low 24999", 32'(clk_out[0]), 32'h0);
        runTo(25000);
        checkOutput("rise 10000 after sync", 32'(clk_out), 32'hF);

        // Disable ch3 while high, then reset mid-period.
        runTo(26000);
        applyStimulus(4'h7, 1'b0, 1'b0, 4'd0, '0);
        step();
        checkOutput("ch3 disabled", 32'(clk_out), 32'h7);
        runTo(27000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst clk_out", 32'(clk_out), 32'h0);
        checkOutput("rst tick", 32'(tick), 32'h0);
        checkOutput("rst tick_rise", 32'(tick_rise), 32'h0);
        checkOutput("rst pending", 32'(pending), 32'h0);

        // Random traffic with short half-periods.
        applyStimulus(4'hF, 1'b0, 1'b0, 4'd0, '0);
        for (int n = 0; n < 5000; n++) begin
            logic [NUM_CH-1:0] en;
            en = ch_en;
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            applyStimulus(en, ($urandom_range(0, 149) == 0), ($urandom_range(0, 9) == 0),
                          4'($urandom_range(0, 5)), DIV_W'($urandom_range(0, 6)));
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        applyStimulus(4'hF, 1'b0, 1'b0, 4'd0, '0);
        step();
        step();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
